psw_debouncer: RTL and testbench

//   Front end for the game's single push switch. Synchronises the raw mechanical

---
 rtl/psw_debouncer.sv | 162 ++++++++++++++++
 tb/tb_psw_debouncer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/psw_debouncer.sv
// rtl/psw_debouncer.sv - push-switch front end: synchroniser, debounce FSM, press/release/long strobes
// and the shared 1us enable tick.
module psw_debouncer #(
  parameter int C_F_CK    = 135_000_000,
  parameter int C_DBG_ACC = 0,
  parameter int C_DEB_US  = 10_000,
  parameter int C_LONG_US = 1_000_000
) (
  input  logic CK_i,
  input  logic RST_i,
  input  logic XPSW_i,
  output logic US_EE_o,
  output logic XPSW_o,
  output logic PRESS_o,
  output logic RELEASE_o,
  output logic LONG_o,
  output logic HOLD_o
);

  localparam int C_N  = (C_DBG_ACC != 0) ? 4 : C_F_CK / 1_000_000;
  localparam int C_PW = (C_N > 1) ? $clog2(C_N) : 1;
  localparam int C_DW = $clog2(C_DEB_US) + 1;
  localparam int C_LW = $clog2(C_LONG_US) + 1;

  localparam logic [C_PW-1:0] C_PRE_LAST = C_PW'(C_N - 1);
  localparam logic [C_DW-1:0] C_DEB_END  = C_DW'(C_DEB_US);
  localparam logic [C_LW-1:0] C_LNG_END  = C_LW'(C_LONG_US);

  typedef enum logic [1:0] {
    ST_REL     = 2'd0,
    ST_PRS_CHK = 2'd1,
    ST_PRS     = 2'd2,
    ST_REL_CHK = 2'd3
  } state_t;

  logic [1:0]      sync_q, sync_d;
  logic [C_PW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;
  state_t          state_q, state_d;
  logic [C_DW-1:0] deb_q, deb_d, deb_inc;
  logic [C_LW-1:0] lng_q, lng_d, lng_inc;
  logic            xpsw_q, xpsw_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            hold_q, hold_d;
  logic            s;

  assign s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], XPSW_i};
    pre_d  = (pre_q == C_PRE_LAST) ? '0 : pre_q + 1'b1;
    tick_d = (pre_d == C_PRE_LAST);
  end

  // A level change on s always wins over a tick arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    lng_d     = lng_q;
    xpsw_d    = xpsw_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    deb_inc   = deb_q + 1'b1;
    lng_inc   = lng_q + 1'b1;
    case (state_q)
      ST_REL: begin
        if (!s) begin
          state_d = ST_PRS_CHK;
          deb_d   = '0;
        end
      end
      ST_PRS_CHK: begin
        if (s) begin
          state_d = ST_REL;
          deb_d   = '0;
        end else if (tick_q) begin
          if (deb_inc == C_DEB_END) begin
            state_d = ST_PRS;
            deb_d   = '0;
            lng_d   = '0;
            xpsw_d  = 1'b0;
            press_d = 1'b1;
          end else begin
            deb_d = deb_inc;
          end
        end
      end
      ST_PRS: begin
        if (s) begin
          state_d = ST_REL_CHK;
          deb_d   = '0;
        end else if (tick_q && (lng_q != C_LNG_END)) begin
          lng_d = lng_inc;
          if (lng_inc == C_LNG_END) begin
            long_d = 1'b1;
            hold_d = 1'b1;
          end
        end
      end
      ST_REL_CHK: begin
        if (!s) begin
          state_d = ST_PRS;
          deb_d   = '0;
        end else if (tick_q) begin
          if (deb_inc == C_DEB_END) begin
            state_d   = ST_REL;
            deb_d     = '0;
            xpsw_d    = 1'b1;
            release_d = 1'b1;
            hold_d    = 1'b0;
          end else begin
            deb_d = deb_inc;
          end
        end
      end
      default: begin
        state_d = ST_REL;
        deb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      sync_q    <= 2'b11;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      state_q   <= ST_REL;
      deb_q     <= '0;
      lng_q     <= '0;
      xpsw_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      deb_q     <= deb_d;
      lng_q     <= lng_d;
      xpsw_q    <= xpsw_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      hold_q    <= hold_d;
    end
  end

  assign US_EE_o   = tick_q;
  assign XPSW_o    = xpsw_q;
  assign PRESS_o   = press_q;
  assign RELEASE_o = release_q;
  assign LONG_o    = long_q;
  assign HOLD_o    = hold_q;

endmodule

// File: tb/tb_psw_debouncer.sv
// tb/tb_psw_debouncer.sv - scoreboard bench for psw_debouncer with 4-cycle tick, 8-tick debounce, 50-tick long.
module tb_psw_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic xpsw_i;
  logic us_ee_o, xpsw_o, press_o, release_o, long_o, hold_o;

  psw_debouncer #(
    .C_F_CK   (135_000_000),
    .C_DBG_ACC(1),
    .C_DEB_US (8),
    .C_LONG_US(50)
  ) dut (
    .CK_i     (clk),
    .RST_i    (rst),
    .XPSW_i   (xpsw_i),
    .US_EE_o  (us_ee_o),
    .XPSW_o   (xpsw_o),
    .PRESS_o  (press_o),
    .RELEASE_o(release_o),
    .LONG_o   (long_o),
    .HOLD_o   (hold_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] EV_PRESS = 3'b001;
  localparam logic [2:0] EV_REL   = 3'b010;
  localparam logic [2:0] EV_LONG  = 3'b100;

  typedef struct {
    string      name;
    logic [2:0] kind;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic expect_ev(input string name, input logic [2:0] kind, input int lo, input int hi);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] ev;
  exp_t       cur;

  initial begin
    forever begin
      @(negedge clk);
      ev = {long_o, release_o, press_o};
      if (ev != 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", int'(ev), 0);
        end else begin
          cur = sb.pop_front();
          check({cur.name, "_kind"}, int'(ev), int'(cur.kind));
          check_win({cur.name, "_cycle"}, cyc, cur.lo, cur.hi);
          if (ev == EV_PRESS) check({cur.name, "_xpsw"}, int'(xpsw_o), 0);
          if (ev == EV_REL) begin
            check({cur.name, "_xpsw"}, int'(xpsw_o), 1);
            check({cur.name, "_hold"}, int'(hold_o), 0);
          end
          if (ev == EV_LONG) check({cur.name, "_hold"}, int'(hold_o), 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  int  c0, p;
  bit  found;

  initial begin
    rst    = 1'b1;
    xpsw_i = 1'b0;
    wait_cyc(3);
    check("rst_xpsw", int'(xpsw_o), 1);
    check("rst_strobes", int'({press_o, release_o, long_o, hold_o}), 0);
    check("rst_tick", int'(us_ee_o), 0);

    rst    = 1'b0;
    xpsw_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("tick_%0d", i), int'(us_ee_o), (i % 4 == 3) ? 1 : 0);
    end

    // clean press and release
    xpsw_i = 1'b0;
    c0 = cyc;
    expect_ev("press_clean", EV_PRESS, c0 + 32, c0 + 35);
    wait_cyc(40);
    check("clean_xpsw_low", int'(xpsw_o), 0);
    check("clean_hold_low", int'(hold_o), 0);
    xpsw_i = 1'b1;
    c0 = cyc;
    expect_ev("release_clean", EV_REL, c0 + 32, c0 + 35);
    wait_cyc(40);
    check("clean_xpsw_high", int'(xpsw_o), 1);

    // press bounce, then long hold
    xpsw_i = 1'b0;
    wait_cyc(20);
    xpsw_i = 1'b1;
    wait_cyc(4);
    xpsw_i = 1'b0;
    c0 = cyc;
    expect_ev("press_bounce", EV_PRESS, c0 + 32, c0 + 35);
    expect_ev("long_hold", EV_LONG, c0 + 232, c0 + 235);
    wait_cyc(40);
    check("bounce_xpsw_low", int'(xpsw_o), 0);
    wait_cyc(275);
    check("long_hold_level", int'(hold_o), 1);
    xpsw_i = 1'b1;
    c0 = cyc;
    expect_ev("release_long", EV_REL, c0 + 32, c0 + 35);
    wait_cyc(40);
    check("long_released_xpsw", int'(xpsw_o), 1);
    check("long_released_hold", int'(hold_o), 0);

    // release bounce while pressed: 3 ticks lost, long fires 12 cycles late
    xpsw_i = 1'b0;
    c0 = cyc;
    expect_ev("press_rb", EV_PRESS, c0 + 32, c0 + 35);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (press_o) found = 1'b1;
    end
    check("press_rb_seen", int'(found), 1);
    p = cyc;
    expect_ev("long_rb", EV_LONG, p + 212, p + 212);
    wait_cyc(28);
    xpsw_i = 1'b1;
    wait_cyc(6);
    check("rb_mid_xpsw", int'(xpsw_o), 0);
    wait_cyc(6);
    xpsw_i = 1'b0;
    wait_cyc(10);
    check("rb_after_xpsw", int'(xpsw_o), 0);
    wait_cyc(180);
    check("rb_hold_level", int'(hold_o), 1);

    // reset while pressed and holding
    rst = 1'b1;
    wait_cyc(2);
    check("midrst_xpsw", int'(xpsw_o), 1);
    check("midrst_hold", int'(hold_o), 0);
    check("midrst_strobes", int'({press_o, release_o, long_o}), 0);
    rst = 1'b0;
    c0 = cyc;
    expect_ev("press_after_rst", EV_PRESS, c0 + 32, c0 + 32);
    wait_cyc(40);
    check("after_rst_xpsw", int'(xpsw_o), 0);
    xpsw_i = 1'b1;
    c0 = cyc;
    expect_ev("release_final", EV_REL, c0 + 32, c0 + 35);
    wait_cyc(40);
    check("final_xpsw", int'(xpsw_o), 1);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
